// File: rtl/s_result_accumulator_if.sv
// Handshake and result bus between the upstream S producer/consumer logic and
// the result accumulator. The master drives control and samples; the slave
// (the accumulator) drives the ready/status flags and window results.
interface s_result_accumulator_if #(
  parameter int IN_W  = 6,
  parameter int CNT_W = 5,
  parameter int SUM_W = 9
);
  logic             start;
  logic             abort;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [SUM_W-1:0] sum;
  logic [IN_W-1:0]  max_val;
  logic [IN_W-1:0]  min_val;
  logic [IN_W-1:0]  avg;
  logic [CNT_W-1:0] count;

  modport master (
    output start, abort, in_valid, in_data,
    input  in_ready, busy, done, sum, max_val, min_val, avg, count
  );

  modport slave (
    input  start, abort, in_valid, in_data,
    output in_ready, busy, done, sum, max_val, min_val, avg, count
  );
endinterface

// File: rtl/s_result_accumulator.sv
// Accumulates a fixed window of COUNT samples of the S result bus and reports
// sum, maximum, minimum and average. Results are held after completion or an
// abort until the next accepted start.
module s_result_accumulator #(
  parameter int IN_W  = 6,
  parameter int COUNT = 8,
  parameter int CNT_W = 5,
  parameter int SUM_W = 9
) (
  input logic                   clk,
  input logic                   rst_n,
  s_result_accumulator_if.slave bus
);

  localparam int LOG2_COUNT = $clog2(COUNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [IN_W-1:0]  max_q, max_d;
  logic [IN_W-1:0]  min_q, min_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic clear_win;
  logic accept;

  // Next-state and control decode: start opens a window, abort always wins,
  // the COUNT-th accepted sample closes it.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    clear_win = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.abort && bus.start) begin
          state_d   = S_ACCUM;
          clear_win = 1'b1;
        end
      end
      S_ACCUM: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.in_valid) begin
          accept = 1'b1;
          if (count_q == CNT_W'(COUNT - 1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Window datapath: clear on start, fold in each accepted sample, else hold.
  always_comb begin
    sum_d   = sum_q;
    max_d   = max_q;
    min_d   = min_q;
    count_d = count_q;
    if (clear_win) begin
      sum_d   = '0;
      max_d   = '0;
      min_d   = '1;
      count_d = '0;
    end else if (accept) begin
      sum_d   = sum_q + SUM_W'(bus.in_data);
      count_d = count_q + CNT_W'(1);
      if (bus.in_data > max_q) max_d = bus.in_data;
      if (bus.in_data < min_q) min_d = bus.in_data;
    end
  end

  // State and result registers; reset forces the idle/cleared values at once.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      sum_q   <= '0;
      max_q   <= '0;
      min_q   <= '1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
      min_q   <= min_d;
      count_q <= count_d;
    end
  end

  // Status flags decode straight from the state; results come from registers.
  assign bus.in_ready = (state_q == S_ACCUM);
  assign bus.busy     = (state_q == S_ACCUM);
  assign bus.done     = (state_q == S_DONE);
  assign bus.sum      = sum_q;
  assign bus.max_val  = max_q;
  assign bus.min_val  = min_q;
  assign bus.count    = count_q;
  assign bus.avg      = sum_q[LOG2_COUNT+IN_W-1:LOG2_COUNT];

endmodule
